// File: rtl/fpu_conv_pkg.sv
// rtl/fpu_conv_pkg.sv - shared FPU conversion types: state enum, round modes, flag indices
package fpu_conv_pkg;

    typedef enum logic [2:0] {
        GET_A   = 3'd0,
        UNPACK  = 3'd1,
        SPECIAL = 3'd2,
        ALIGN   = 3'd3,
        ROUND   = 3'd4,
        PUT_Z   = 3'd5
    } conv_state_t;

    localparam logic [1:0] RM_RTZ = 2'd0;
    localparam logic [1:0] RM_RNE = 2'd1;
    localparam logic [1:0] RM_RDN = 2'd2;
    localparam logic [1:0] RM_RUP = 2'd3;

    localparam int FLG_INVALID  = 2;
    localparam int FLG_OVERFLOW = 1;
    localparam int FLG_INEXACT  = 0;

endpackage

// File: rtl/float_to_int_round.sv
// rtl/float_to_int_round.sv - combinational rounding of an aligned magnitude using guard/sticky bits
module float_to_int_round
    import fpu_conv_pkg::*;
#(
    parameter int MAG_W = 34
) (
    input  logic [MAG_W-1:0] mag,
    input  logic             g,
    input  logic             s,
    input  logic             sign,
    input  logic [1:0]       mode,
    output logic [MAG_W-1:0] rounded
);

    logic inc;

    always_comb begin
        inc = 1'b0;
        case (mode)
            RM_RTZ:  inc = 1'b0;
            RM_RNE:  inc = g & (s | mag[0]);
            RM_RDN:  inc = sign & (g | s);
            RM_RUP:  inc = ~sign & (g | s);
            default: inc = 1'b0;
        endcase
    end

    // Magnitude carries headroom above the result width, so the increment cannot wrap.
    assign rounded = mag + MAG_W'(inc);

endmodule

// File: rtl/float_to_int_param.sv
// rtl/float_to_int_param.sv - parametrised float to integer converter with rounding, saturation and flags
module float_to_int_param
    import fpu_conv_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int MAN_W  = 23,
    parameter int INT_W  = 32,
    parameter int SIGNED = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [EXP_W+MAN_W:0]   input_a,
    input  logic [1:0]             input_a_mode,
    input  logic                   input_a_stb,
    output logic                   input_a_ack,
    output logic [INT_W-1:0]       output_z,
    output logic [2:0]             output_z_flags,
    output logic                   output_z_stb,
    input  logic                   output_z_ack
);

    localparam int EW    = EXP_W + 2;
    localparam int MAG_W = INT_W + 2;
    localparam int FB    = MAN_W + 1;
    localparam int WW    = MAG_W + FB;
    localparam int BIAS  = 2**(EXP_W-1) - 1;

    localparam logic [MAG_W-1:0] POS_LIMIT = (SIGNED != 0) ? ((MAG_W'(1) << (INT_W-1)) - MAG_W'(1))
                                                          : ((MAG_W'(1) << INT_W) - MAG_W'(1));
    localparam logic [MAG_W-1:0] NEG_LIMIT = (SIGNED != 0) ? (MAG_W'(1) << (INT_W-1)) : '0;
    localparam logic [INT_W-1:0] SAT_POS   = (SIGNED != 0) ? {1'b0, {(INT_W-1){1'b1}}} : {INT_W{1'b1}};
    localparam logic [INT_W-1:0] SAT_NEG   = (SIGNED != 0) ? {1'b1, {(INT_W-1){1'b0}}} : {INT_W{1'b0}};

    conv_state_t state, state_next;

    logic                   a_sign;
    logic [EXP_W-1:0]       a_exp;
    logic [MAN_W-1:0]       a_man;
    logic [1:0]             a_mode;
    logic signed [EW-1:0]   e_val;
    logic [MAN_W:0]         mant;
    logic [MAG_W-1:0]       mag_r;
    logic                   g_r;
    logic                   s_r;
    logic [INT_W-1:0]       res_z;
    logic [2:0]             res_flags;
    logic                   ack_r;
    logic                   stb_r;

    logic                   exp_ones;
    logic                   exp_zero;
    logic                   man_nz;
    logic                   e_big;
    logic                   is_special;
    logic [WW-1:0]          shifted;
    logic [MAG_W-1:0]       m_rnd;
    logic [INT_W-1:0]       m_lo;
    logic                   in_range;

    assign input_a_ack  = ack_r;
    assign output_z_stb = stb_r;

    assign exp_ones   = &a_exp;
    assign exp_zero   = (a_exp == '0);
    assign man_nz     = (a_man != '0);
    assign e_big      = (e_val > $signed(EW'(INT_W)));
    assign is_special = exp_ones | exp_zero | e_big;

    // Fixed point with FB fraction bits: the top fraction bit becomes the guard.
    assign shifted = WW'({mant, 1'b0}) << e_val[EW-2:0];

    float_to_int_round #(.MAG_W(MAG_W)) u_round (
        .mag     (mag_r),
        .g       (g_r),
        .s       (s_r),
        .sign    (a_sign),
        .mode    (a_mode),
        .rounded (m_rnd)
    );

    assign m_lo     = m_rnd[INT_W-1:0];
    assign in_range = a_sign ? (m_rnd <= NEG_LIMIT) : (m_rnd <= POS_LIMIT);

    always_ff @(posedge clk) begin
        if (rst) state <= GET_A;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            GET_A:   if (ack_r && input_a_stb) state_next = UNPACK;
            UNPACK:  state_next = SPECIAL;
            SPECIAL: state_next = is_special ? PUT_Z : ALIGN;
            ALIGN:   state_next = ROUND;
            ROUND:   state_next = PUT_Z;
            PUT_Z:   if (stb_r && output_z_ack) state_next = GET_A;
            default: state_next = GET_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r          <= 1'b0;
            stb_r          <= 1'b0;
            output_z       <= '0;
            output_z_flags <= '0;
        end else begin
            case (state)
                GET_A: begin
                    if (ack_r && input_a_stb) begin
                        ack_r  <= 1'b0;
                        a_sign <= input_a[EXP_W+MAN_W];
                        a_exp  <= input_a[EXP_W+MAN_W-1:MAN_W];
                        a_man  <= input_a[MAN_W-1:0];
                        a_mode <= input_a_mode;
                    end else begin
                        ack_r <= 1'b1;
                    end
                end
                UNPACK: begin
                    e_val <= $signed({2'b00, a_exp}) - $signed(EW'(BIAS));
                    mant  <= {1'b1, a_man};
                end
                SPECIAL: begin
                    res_flags <= '0;
                    if (exp_ones && man_nz) begin
                        res_z                  <= '0;
                        res_flags[FLG_INVALID] <= 1'b1;
                    end else if (exp_ones || (!exp_zero && e_big)) begin
                        res_z                   <= a_sign ? SAT_NEG : SAT_POS;
                        res_flags[FLG_OVERFLOW] <= 1'b1;
                    end else if (exp_zero) begin
                        res_z                  <= '0;
                        res_flags[FLG_INEXACT] <= man_nz;
                    end
                end
                ALIGN: begin
                    if (e_val < 0) begin
                        mag_r <= '0;
                        g_r   <= (e_val == -1);
                        s_r   <= (e_val == -1) ? (a_man != '0) : 1'b1;
                    end else begin
                        mag_r <= shifted[WW-1:FB];
                        g_r   <= shifted[FB-1];
                        s_r   <= |shifted[FB-2:0];
                    end
                end
                ROUND: begin
                    res_flags <= '0;
                    if (in_range) begin
                        res_z                  <= a_sign ? (~m_lo + 1'b1) : m_lo;
                        res_flags[FLG_INEXACT] <= g_r | s_r;
                    end else begin
                        res_z                   <= a_sign ? SAT_NEG : SAT_POS;
                        res_flags[FLG_OVERFLOW] <= 1'b1;
                    end
                end
                PUT_Z: begin
                    if (!stb_r) begin
                        stb_r          <= 1'b1;
                        output_z       <= res_z;
                        output_z_flags <= res_flags;
                    end else if (output_z_ack) begin
                        stb_r <= 1'b0;
                    end
                end
                default: ack_r <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_float_to_int_param.sv
// tb/tb_float_to_int_param.sv - scoreboard bench for signed and unsigned float_to_int_param instances
module tb_float_to_int_param;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] a_in = '0;
    logic [1:0]  mode = '0;
    logic        stb_s = 1'b0, stb_u = 1'b0;
    logic        ack_s, ack_u;
    logic [31:0] z_s, z_u;
    logic [2:0]  f_s, f_u;
    logic        zstb_s, zstb_u;
    logic        z_ack = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;

    logic [34:0] q_s[$];
    logic [34:0] q_u[$];

    always #5 clk = ~clk;

    float_to_int_param #(.EXP_W(8), .MAN_W(23), .INT_W(32), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .input_a(a_in), .input_a_mode(mode), .input_a_stb(stb_s),
        .input_a_ack(ack_s), .output_z(z_s), .output_z_flags(f_s), .output_z_stb(zstb_s),
        .output_z_ack(z_ack)
    );

    float_to_int_param #(.EXP_W(8), .MAN_W(23), .INT_W(32), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .input_a(a_in), .input_a_mode(mode), .input_a_stb(stb_u),
        .input_a_ack(ack_u), .output_z(z_u), .output_z_flags(f_u), .output_z_stb(zstb_u),
        .output_z_ack(z_ack)
    );

    task automatic check(input string name, input logic [34:0] got, input logic [34:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got flags=%b z=%h, expected flags=%b z=%h",
                     name, got[34:32], got[31:0], exp[34:32], exp[31:0]);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && zstb_s && z_ack) begin
            if (q_s.size() == 0) check("signed_unexpected", {f_s, z_s}, 35'h7_FFFF_FFFF);
            else check("signed_result", {f_s, z_s}, q_s.pop_front());
        end
        if (!rst && zstb_u && z_ack) begin
            if (q_u.size() == 0) check("unsigned_unexpected", {f_u, z_u}, 35'h7_FFFF_FFFF);
            else check("unsigned_result", {f_u, z_u}, q_u.pop_front());
        end
    end

    // Returns #1 after the accept edge; expectation is queued only when push is set.
    task automatic send(input logic [31:0] a, input logic [1:0] m, input bit uns,
                        input bit push, input logic [31:0] ez, input logic [2:0] ef);
        int n;
        @(negedge clk);
        a_in = a; mode = m; stb_s = !uns; stb_u = uns;
        n = 0;
        while (!(uns ? ack_u : ack_s) && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("accept_timeout", 35'd0, 35'd1);
        if (push) begin
            if (uns) q_u.push_back({ef, ez});
            else     q_s.push_back({ef, ez});
        end
        @(posedge clk);
        #1;
        stb_s = 1'b0; stb_u = 1'b0;
        a_in = 32'h7F80_0000; mode = 2'd3;
    endtask

    initial begin
        int k;
        repeat (3) @(posedge clk);
        #1;
        check("reset_s", {ack_s, zstb_s, f_s, z_s}, 37'd0);
        check("reset_u", {ack_u, zstb_u, f_u, z_u}, 37'd0);
        @(negedge clk);
        rst = 1'b0;

        send(32'h4020_0000, 2'd0, 0, 1, 32'h0000_0002, 3'b001);
        send(32'h4020_0000, 2'd1, 0, 1, 32'h0000_0002, 3'b001);
        send(32'h4020_0000, 2'd3, 0, 1, 32'h0000_0003, 3'b001);
        send(32'hC020_0000, 2'd2, 0, 1, 32'hFFFF_FFFD, 3'b001);
        send(32'h4040_0000, 2'd1, 0, 1, 32'h0000_0003, 3'b000);
        send(32'h4040_0000, 2'd2, 0, 1, 32'h0000_0003, 3'b000);
        send(32'h3F00_0000, 2'd1, 0, 1, 32'h0000_0000, 3'b001);
        send(32'h3FC0_0000, 2'd1, 0, 1, 32'h0000_0002, 3'b001);
        send(32'h4F00_0000, 2'd0, 0, 1, 32'h7FFF_FFFF, 3'b010);
        send(32'hCF00_0000, 2'd0, 0, 1, 32'h8000_0000, 3'b000);
        send(32'h7FC0_0000, 2'd0, 0, 1, 32'h0000_0000, 3'b100);
        send(32'hFF80_0000, 2'd0, 0, 1, 32'h8000_0000, 3'b010);
        send(32'h7F80_0000, 2'd1, 0, 1, 32'h7FFF_FFFF, 3'b010);
        send(32'h0000_0000, 2'd3, 0, 1, 32'h0000_0000, 3'b000);

        send(32'hBF00_0000, 2'd0, 1, 1, 32'h0000_0000, 3'b001);
        send(32'hBF80_0000, 2'd0, 1, 1, 32'h0000_0000, 3'b010);
        send(32'h4F80_0000, 2'd0, 1, 1, 32'hFFFF_FFFF, 3'b010);
        send(32'h0000_0001, 2'd0, 1, 1, 32'h0000_0000, 3'b001);
        send(32'h4F7F_FFFF, 2'd0, 1, 1, 32'hFFFF_FF00, 3'b000);

        // Latency and back-pressure on a normal-path operand.
        @(negedge clk);
        while (zstb_s) @(negedge clk);
        z_ack = 1'b0;
        send(32'h4040_0000, 2'd0, 0, 1, 32'h0000_0003, 3'b000);
        k = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (zstb_s) begin
                k = i;
                break;
            end
        end
        check("latency_edges", 35'(k), 35'd5);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("hold_z", {f_s, z_s}, {3'b000, 32'h0000_0003});
            check("hold_ack_stb", 35'({ack_s, zstb_s}), 35'b01);
        end
        z_ack = 1'b1;
        @(posedge clk);
        #1;
        check("after_xfer", 35'({ack_s, zstb_s}), 35'b00);
        @(posedge clk);
        #1;
        check("ack_rises", 35'({ack_s, zstb_s}), 35'b10);

        // Abort in ALIGN: reset sampled on edge 3 after accept.
        send(32'h4020_0000, 2'd0, 0, 0, 32'h0, 3'b000);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_outputs", 35'({ack_s, zstb_s}), 35'b00);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (zstb_s) check("abort_no_result", 35'd1, 35'd0);
        end
        send(32'h4020_0000, 2'd3, 0, 1, 32'h0000_0003, 3'b001);

        k = 0;
        while ((q_s.size() != 0 || q_u.size() != 0) && k < 200) begin
            @(posedge clk);
            k++;
        end
        if (k >= 200) check("drain_timeout", 35'(q_s.size() + q_u.size()), 35'd0);
        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
